// File: rtl/cv_hb_mon.sv
// Heartbeat monitor: synchronizes an asynchronous toggle and measures its half-periods.
// It reports alive/lost status and counts out-of-window or missing heartbeat edges.
module cv_hb_mon #(
    parameter int unsigned CLKFREQ  = 16000000,
    parameter int unsigned EXP_HALF = CLKFREQ / 2,
    parameter int unsigned TOL      = EXP_HALF / 16,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hbin,
    output logic        alive,
    output logic        lost,
    output logic        err_pulse,
    output logic [29:0] last_half,
    output logic [7:0]  err_count
);

    localparam logic [29:0] WinLo    = 30'(EXP_HALF - TOL);
    localparam logic [29:0] TMax     = 30'(EXP_HALF + TOL);
    localparam logic [3:0]  LockGoal = 4'(LOCK_CNT);

    typedef enum logic [1:0] {StIdle, StAcq, StLocked, StLost} state_e;

    state_e      state_q, state_d;
    logic        s1, s2, s3;
    logic [29:0] cnt_q;
    logic [29:0] meas;
    logic [3:0]  good_q, good_d;
    logic [3:0]  good_inc;
    logic        hb_edge, timeout, inwin, err_ev, upd_last;

    assign hb_edge  = s2 ^ s3;
    assign meas     = cnt_q + 30'd1;
    assign inwin    = (meas >= WinLo) && (meas <= TMax);
    // An edge landing on cnt==TMAX wins over the timeout and is judged as meas=TMAX+1.
    assign timeout  = (cnt_q == TMax) && !hb_edge;
    assign good_inc = good_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        err_ev   = 1'b0;
        upd_last = 1'b0;
        unique case (state_q)
            StIdle, StLost: begin
                // The interval ending at the first edge is meaningless and discarded.
                if (hb_edge) begin
                    state_d = StAcq;
                    good_d  = 4'd0;
                end else if (timeout) begin
                    state_d = StLost;
                end
            end
            StAcq: begin
                if (hb_edge) begin
                    upd_last = 1'b1;
                    if (inwin) begin
                        good_d = good_inc;
                        if (good_inc == LockGoal) state_d = StLocked;
                    end else begin
                        good_d = 4'd0;
                        err_ev = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = StLost;
                    err_ev  = 1'b1;
                end
            end
            StLocked: begin
                if (hb_edge) begin
                    upd_last = 1'b1;
                    if (!inwin) begin
                        state_d = StAcq;
                        good_d  = 4'd0;
                        err_ev  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = StLost;
                    err_ev  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StIdle;
            good_q    <= '0;
            alive     <= 1'b0;
            lost      <= 1'b0;
            err_pulse <= 1'b0;
            last_half <= '0;
            err_count <= '0;
        end else begin
            s1 <= hbin;
            s2 <= s1;
            s3 <= s2;
            if (hb_edge) begin
                cnt_q <= '0;
            end else if (cnt_q != TMax) begin
                cnt_q <= cnt_q + 30'd1;
            end
            state_q   <= state_d;
            good_q    <= good_d;
            alive     <= (state_d == StLocked);
            lost      <= (state_d == StLost);
            err_pulse <= err_ev;
            if (upd_last) last_half <= meas;
            if (err_ev && (err_count != 8'hff)) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_cv_hb_mon.sv
// Bench for cv_hb_mon: drives heartbeat half-periods and compares outputs one cycle
// after each edge strobe against an interval-level model of the monitor.
module tb_cv_hb_mon;

    localparam int M_IDLE = 0;
    localparam int M_ACQ  = 1;
    localparam int M_LOCK = 2;
    localparam int M_LOST = 3;
    localparam int WLO    = 30;
    localparam int WHI    = 34;
    localparam int LOCKN  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hbin = 1'b0;
    logic        alive, lost, err_pulse;
    logic [29:0] last_half;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_ref = 0;

    int m_st, m_good, m_err, m_last;
    bit m_pulse;

    logic [40:0] obs;
    assign obs = {alive, lost, err_pulse, err_count, last_half};

    cv_hb_mon #(.CLKFREQ(64), .EXP_HALF(32), .TOL(2), .LOCK_CNT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .hbin      (hbin),
        .alive     (alive),
        .lost      (lost),
        .err_pulse (err_pulse),
        .last_half (last_half),
        .err_count (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [40:0] exp_vec();
        return {m_st == M_LOCK, m_st == M_LOST, m_pulse, 8'(m_err), 30'(m_last)};
    endfunction

    function automatic void model_reset();
        m_st = M_IDLE; m_good = 0; m_err = 0; m_last = 0; m_pulse = 0;
    endfunction

    // A missing edge: the source is considered lost; only a live link counts it as an error.
    function automatic void model_timeout();
        if (m_st == M_ACQ || m_st == M_LOCK) m_err = (m_err < 255) ? m_err + 1 : 255;
        m_st = M_LOST;
    endfunction

    // An edge arrives `meas` cycles after the previous one (or the virtual one at reset).
    function automatic void model_edge(input int meas);
        bit good;
        m_pulse = 0;
        if (meas > WHI + 1) model_timeout();
        good = (meas >= WLO) && (meas <= WHI);
        if (m_st == M_IDLE || m_st == M_LOST) begin
            m_st = M_ACQ;
            m_good = 0;
        end else begin
            m_last = meas;
            if (good) begin
                if (m_st == M_ACQ) begin
                    m_good++;
                    if (m_good == LOCKN) m_st = M_LOCK;
                end
            end else begin
                m_st = M_ACQ;
                m_good = 0;
                m_err = (m_err < 255) ? m_err + 1 : 255;
                m_pulse = 1;
            end
        end
    endfunction

    // Toggle hbin d cycles after the previous toggle, then settle to strobe + 1 cycle.
    task automatic do_half(input int d);
        while (cyc < t_ref + d) begin
            @(posedge clk); #1;
        end
        hbin = ~hbin;
        t_ref = cyc;
        repeat (3) @(posedge clk);
        #1;
        model_edge(d);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        t_ref = cyc - 3;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hbin = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (obs !== 41'd0) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", obs, 41'd0);
        end
        release_reset();
        repeat (34) @(posedge clk);
        #1;
        checks++;
        if (lost !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_early_lost: got %b expected 0", lost);
        end
        @(posedge clk); #1;
        model_timeout();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL idle_timeout_lost: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_lock(input int d);
        do_half(40);
        for (int i = 0; i < LOCKN; i++) begin
            do_half(d);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL lock_%0d_step%0d: got %h expected %h", d, i, obs, exp_vec());
            end
        end
        checks++;
        if (alive !== 1'b1 || last_half !== 30'(d) || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL lock_%0d_final: got alive=%b last=%0d pulse=%b expected 1 %0d 0",
                     d, alive, last_half, err_pulse, d);
        end
    endtask

    task automatic test_out_of_window();
        int bad [2] = '{29, 35};
        for (int k = 0; k < 2; k++) begin
            do_half(bad[k]);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL oow_%0d: got %h expected %h", bad[k], obs, exp_vec());
            end
            for (int i = 0; i < LOCKN; i++) begin
                do_half(32);
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL oow_relock_%0d_%0d: got %h expected %h",
                             bad[k], i, obs, exp_vec());
                end
            end
        end
    endtask

    task automatic test_loss();
        while (cyc < t_ref + 45) begin
            @(posedge clk); #1;
        end
        model_timeout();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL loss_detect: got %h expected %h", obs, exp_vec());
        end
        do_half(70);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL loss_resume: got %h expected %h", obs, exp_vec());
        end
        for (int i = 0; i < LOCKN; i++) begin
            do_half(32);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL loss_relock_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_boundary();
        for (int i = 0; i < LOCKN + 1; i++) do_half(32);
        do_half(35);
        checks++;
        if (obs !== exp_vec() || last_half !== 30'd35 || err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL edge_at_tmax: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 80; i++) begin
            d = ($urandom_range(0, 2) == 0) ? 32 : int'($urandom_range(27, 37));
            do_half(d);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random_%0d_d%0d: got %h expected %h", i, d, obs, exp_vec());
            end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            do_half(20);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL saturate_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL saturate_final: got %0d expected 255", err_count);
        end
    endtask

    task automatic test_reset_mid();
        int seq [11] = '{32, 32, 32, 32, 32, 29, 25, 25, 32, 32, 32};
        reset = 1'b1;
        hbin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        foreach (seq[i]) do_half(seq[i]);
        do_half(32);
        checks++;
        if (obs !== exp_vec() || alive !== 1'b1 || err_count !== 8'd3) begin
            errors++;
            $display("FAIL mid_setup: got %h expected %h", obs, exp_vec());
        end
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b1;
        hbin = 1'b0;
        #1;
        checks++;
        if (obs !== 41'd0) begin
            errors++;
            $display("FAIL mid_reset_immediate: got %h expected %h", obs, 41'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        do_half(32);
        checks++;
        if (obs !== exp_vec() || obs !== 41'd0) begin
            errors++;
            $display("FAIL mid_first_edge_discard: got %h expected %h", obs, exp_vec());
        end
        do_half(32);
        checks++;
        if (obs !== exp_vec() || last_half !== 30'd32) begin
            errors++;
            $display("FAIL mid_second_edge: got %h expected %h", obs, exp_vec());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock(32);
        test_lock(30);
        test_lock(34);
        test_out_of_window();
        test_loss();
        test_boundary();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cv_hb_mon.md
Name: cv_hb_mon

Overview:
- Heartbeat monitor: the receiving end of the board heartbeat toggle.
- Samples an asynchronous heartbeat input and measures the clock count between its edges (half-periods).
- Declares the source alive after a run of in-tolerance half-periods.
- Flags loss and out-of-tolerance edges, with a saturating error counter for status registers and LEDs.

Parameters:
- CLKFREQ, 16000000: monitor clock frequency in Hz.
- EXP_HALF, CLKFREQ/2: expected half-period in clk cycles.
- TOL, EXP_HALF/16: allowed deviation in cycles. Window is EXP_HALF-TOL .. EXP_HALF+TOL inclusive.
- LOCK_CNT, 4: consecutive in-window half-periods required to declare alive. Range 1..15.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- hbin  input  1  heartbeat toggle, asynchronous to clk.
- alive  output  1  high while state is LOCKED.
- lost  output  1  high while state is LOST.
- err_pulse  output  1  one-cycle strobe per detected error.
- last_half  output  30  most recent measured half-period in cycles.
- err_count  output  8  saturating error count.

Behaviour:
- Reset: clk is the clock; reset is asynchronous and active-high. All flops clear to 0. State=IDLE; alive=0, lost=0, err_pulse=0, last_half=0, err_count=0. Reset asserted mid-operation aborts immediately to these values.
- Input path: 2-flop synchronizer (s1, s2), then a third flop s3. edge = s2 ^ s3, i.e. both polarities. An hbin change produces edge 3 cycles later, ±1 cycle of sync uncertainty.
- Interval counter cnt, 30 bit:
  - On edge: cnt<=0 and meas=cnt+1, so meas equals the cycle distance between consecutive edge strobes.
  - Otherwise cnt increments, holding at TMAX=EXP_HALF+TOL.
- inwin = (meas >= EXP_HALF-TOL) && (meas <= EXP_HALF+TOL).
- Timeout: cnt==TMAX and no edge this cycle. If an edge coincides with cnt==TMAX, the edge wins; meas=TMAX+1 is out-of-window.
- good counter: 4 bit.
- FSM transitions (registered; outputs reflect new state the cycle after the event):
  - IDLE, edge: ->ACQ, good=0. Interval is discarded and last_half is not updated.
  - IDLE, timeout: ->LOST. No error is counted.
  - ACQ, edge & inwin: good+1. When good+1==LOCK_CNT, ->LOCKED. last_half<=meas.
  - ACQ, edge & !inwin: good=0, stay in ACQ, error. last_half<=meas.
  - ACQ, timeout: ->LOST, error.
  - LOCKED, edge & inwin: stay. last_half<=meas.
  - LOCKED, edge & !inwin: ->ACQ, good=0, error. last_half<=meas.
  - LOCKED, timeout: ->LOST, error.
  - LOST, edge: ->ACQ, good=0. Interval is discarded. While in LOST, cnt holds at TMAX and no further errors occur.
- Error handling: err_pulse=1 for exactly the cycle after the error event. err_count increments by 1 and saturates at 255; it is never cleared except by reset.
- alive and lost are registered decodes of state. They are never both 1.
- Timing from an edge strobe: ACQ->LOCKED needs LOCK_CNT good intervals after the first edge, i.e. LOCK_CNT+1 edges total. alive rises 1 cycle after the strobe of the final good edge.

Test Plan:
All scenarios use CLKFREQ=64, so EXP_HALF=32, TOL=2, window 30..34, TMAX=34, LOCK_CNT=4.
- Reset/idle: hold reset 5 cycles, then hbin=0. All outputs 0 after reset. lost rises 35 cycles after the first post-reset edge of clk, with err_count=0.
- Lock: toggle hbin every 32 cycles. alive=1 one cycle after the 5th edge strobe; last_half=32; err_pulse never fires. Toggles at 30 and at 34 also lock; last_half reads 30 or 34 respectively.
- Out-of-window while LOCKED: after lock, one half-period of 29 -> alive falls, err_pulse one cycle, err_count=1, last_half=29. Next 4 intervals of 32 -> alive returns. Repeat with 35 -> err_count=2.
- Loss: after lock, stop toggling -> lost=1 and alive=0, err_count +1. Resume toggling every 32 -> lost falls one cycle after the first edge; alive after 4 further good intervals.
- Saturation/boundary: 300 intervals of 20 cycles -> err_count=255, never wraps. An edge exactly when cnt==34 is treated as error with last_half=35, not as a timeout.
- Reset mid-operation: assert reset while LOCKED with err_count=3 -> all outputs 0 immediately. After release, FSM is in IDLE and the first edge is discarded.
